// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong ball engine.
package pong_pkg;

  // Ball engine game states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    MISS  = 2'd2,
    SERVE = 2'd3
  } state_t;

  // Direction encodings: 1 = right on X, 1 = down on Y.
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_DOWN  = 1'b1;

  // Default board geometry (game units) and ball step period (clocks).
  localparam int DEF_GAME_WIDTH  = 40;
  localparam int DEF_GAME_HEIGHT = 30;
  localparam int DEF_BALL_SPEED  = 1250000;

endpackage

// File: rtl/pong_tick_gen.sv
// Programmable-period tick generator: one-cycle pulse every i_period enabled clocks.
module pong_tick_gen #(
  parameter int C_CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [C_CNT_W-1:0] i_period,
  output logic               o_tick
);

  localparam logic [C_CNT_W-1:0] ONE = {{(C_CNT_W-1){1'b0}}, 1'b1};

  logic [C_CNT_W-1:0] cnt;
  logic [C_CNT_W-1:0] last;

  // >= rather than == so a period shortened mid-count still wraps cleanly.
  assign last   = i_period - ONE;
  assign o_tick = i_en && (cnt >= last);

  // Counter: clear has priority, otherwise count while enabled and wrap on tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      cnt <= '0;
    else if (i_clr) cnt <= '0;
    else if (i_en)  cnt <= o_tick ? '0 : cnt + ONE;
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball engine: moves/bounces the ball, detects misses, re-serves, drives draw enable.
// Optional paddle-bounce speed-up enabled by defining PONG_BALL_SPEEDUP_EN.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int C_GAME_WIDTH    = DEF_GAME_WIDTH,
  parameter int C_GAME_HEIGHT   = DEF_GAME_HEIGHT,
  parameter int C_COORD_W       = 6,
  parameter int C_BALL_SPEED    = DEF_BALL_SPEED,
  parameter int C_CNT_W         = 32,
  parameter int C_PADDLE_HEIGHT = 6,
  parameter int C_P1_COL        = 0,
  parameter int C_P2_COL        = DEF_GAME_WIDTH - 1,
  parameter int C_SERVE_TICKS   = 20
`ifdef PONG_BALL_SPEEDUP_EN
  , parameter int C_SPEEDUP_STEP   = 62500,
  parameter int C_BALL_SPEED_MIN = 312500
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_game_active,
  input  logic [C_COORD_W-1:0] i_col_count_div,
  input  logic [C_COORD_W-1:0] i_row_count_div,
  input  logic [C_COORD_W-1:0] i_paddle_y_p1,
  input  logic [C_COORD_W-1:0] i_paddle_y_p2,
  output logic                 o_draw_ball,
  output logic [C_COORD_W-1:0] o_ball_x,
  output logic [C_COORD_W-1:0] o_ball_y,
  output logic                 o_dir_x,
  output logic                 o_dir_y,
  output logic                 o_p1_score,
  output logic                 o_p2_score
);

  localparam int CW1   = C_COORD_W + 1;
  localparam int SRV_W = (C_SERVE_TICKS < 2) ? 1 : $clog2(C_SERVE_TICKS);

  localparam logic [C_COORD_W-1:0] X_CTR   = C_COORD_W'(C_GAME_WIDTH / 2);
  localparam logic [C_COORD_W-1:0] Y_CTR   = C_COORD_W'(C_GAME_HEIGHT / 2);
  localparam logic [C_COORD_W-1:0] Y_MAX   = C_COORD_W'(C_GAME_HEIGHT - 1);
  localparam logic [C_COORD_W-1:0] P1C     = C_COORD_W'(C_P1_COL);
  localparam logic [C_COORD_W-1:0] P2C     = C_COORD_W'(C_P2_COL);
  localparam logic [C_COORD_W-1:0] P1_APPR = C_COORD_W'(C_P1_COL + 1);
  localparam logic [C_COORD_W-1:0] P2_APPR = C_COORD_W'(C_P2_COL - 1);
  localparam logic [CW1-1:0]       PH_M1   = CW1'(C_PADDLE_HEIGHT - 1);
  localparam logic [SRV_W-1:0]     SRV_LAST = SRV_W'(C_SERVE_TICKS - 1);

  state_t               state_q, state_d;
  logic [C_COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic                 dx_q, dx_d, dy_q, dy_d;
  logic [SRV_W-1:0]     srv_q, srv_d;
  logic                 bounce;
  logic                 tick;
  logic                 tick_en, tick_clr;
  logic [C_CNT_W-1:0]   period;

  // Paddle ranges at one extra bit so a paddle near the bottom cannot wrap.
  logic [CW1-1:0] y_ext, p1_lo, p1_hi, p2_lo, p2_hi;
  logic           hit_p1, hit_p2;

  assign y_ext  = {1'b0, y_q};
  assign p1_lo  = {1'b0, i_paddle_y_p1};
  assign p2_lo  = {1'b0, i_paddle_y_p2};
  assign p1_hi  = p1_lo + PH_M1;
  assign p2_hi  = p2_lo + PH_M1;
  assign hit_p1 = (y_ext >= p1_lo) && (y_ext <= p1_hi);
  assign hit_p2 = (y_ext >= p2_lo) && (y_ext <= p2_hi);

  assign tick_en  = (state_q == RUN) || (state_q == SERVE);
  assign tick_clr = !i_game_active || (state_q == IDLE);

  pong_tick_gen #(.C_CNT_W(C_CNT_W)) u_tick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (tick_clr),
    .i_en     (tick_en),
    .i_period (period),
    .o_tick   (tick)
  );

`ifdef PONG_BALL_SPEEDUP_EN
  logic [C_CNT_W-1:0] period_q;
  assign period = period_q;

  // Active period shrinks per paddle bounce, saturating; restored on MISS/IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      period_q <= C_CNT_W'(C_BALL_SPEED);
    else if (!i_game_active || state_q == IDLE || state_q == MISS)
      period_q <= C_CNT_W'(C_BALL_SPEED);
    else if (bounce) begin
      if (period_q >= C_CNT_W'(C_BALL_SPEED_MIN + C_SPEEDUP_STEP))
        period_q <= period_q - C_CNT_W'(C_SPEEDUP_STEP);
      else
        period_q <= C_CNT_W'(C_BALL_SPEED_MIN);
    end
  end
`else
  assign period = C_CNT_W'(C_BALL_SPEED);
`endif

  // State and ball registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      x_q     <= X_CTR;
      y_q     <= Y_CTR;
      dx_q    <= DIR_RIGHT;
      dy_q    <= DIR_DOWN;
      srv_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      srv_q   <= srv_d;
    end
  end

  // Next state and ball motion; game-inactive overrides everything at the end.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    srv_d   = srv_q;
    bounce  = 1'b0;
    case (state_q)
      IDLE: begin
        x_d     = X_CTR;
        y_d     = Y_CTR;
        dx_d    = DIR_RIGHT;
        dy_d    = DIR_DOWN;
        state_d = RUN;
      end
      RUN: begin
        if (tick) begin
          if (dy_q == DIR_DOWN) begin
            if (y_q == Y_MAX) begin
              dy_d = ~DIR_DOWN;
              y_d  = y_q - 1'b1;
            end else y_d = y_q + 1'b1;
          end else begin
            if (y_q == '0) begin
              dy_d = DIR_DOWN;
              y_d  = y_q + 1'b1;
            end else y_d = y_q - 1'b1;
          end
          if (dx_q == DIR_RIGHT) begin
            if (x_q == P2_APPR && hit_p2) begin
              dx_d   = ~DIR_RIGHT;
              x_d    = x_q - 1'b1;
              bounce = 1'b1;
            end else x_d = x_q + 1'b1;
          end else begin
            if (x_q == P1_APPR && hit_p1) begin
              dx_d   = DIR_RIGHT;
              x_d    = x_q + 1'b1;
              bounce = 1'b1;
            end else x_d = x_q - 1'b1;
          end
          if (x_d == P2C || x_d == P1C) state_d = MISS;
        end
      end
      MISS: begin
        x_d     = X_CTR;
        y_d     = Y_CTR;
        srv_d   = '0;
        state_d = SERVE;
      end
      SERVE: begin
        // Ball left in the direction away from the scorer, so flipping points it at them.
        if (tick) begin
          if (srv_q == SRV_LAST) begin
            srv_d   = '0;
            dx_d    = ~dx_q;
            state_d = RUN;
          end else srv_d = srv_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!i_game_active) begin
      state_d = IDLE;
      x_d     = X_CTR;
      y_d     = Y_CTR;
      dx_d    = DIR_RIGHT;
      dy_d    = DIR_DOWN;
      srv_d   = '0;
      bounce  = 1'b0;
    end
  end

  // Draw enable registered against the current ball cell.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_draw_ball <= 1'b0;
    else       o_draw_ball <= (i_col_count_div == x_q) && (i_row_count_div == y_q);
  end

  // Ball sits on the scorer's opposite goal column during MISS; gate with active.
  assign o_p1_score = (state_q == MISS) && (x_q == P2C) && i_game_active;
  assign o_p2_score = (state_q == MISS) && (x_q == P1C) && i_game_active;

  assign o_ball_x = x_q;
  assign o_ball_y = y_q;
  assign o_dir_x  = dx_q;
  assign o_dir_y  = dy_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Randomized bench for pong_ball_engine against a tick-level game model.
module tb_pong_ball_engine;

  localparam int W = 40, H = 30, CW = 6, SPD = 4, ST = 2, PH = 6, P1 = 0, P2 = 39;

  logic          i_clk = 1'b0;
  logic          i_rst, i_game_active;
  logic [CW-1:0] i_col_count_div, i_row_count_div, i_paddle_y_p1, i_paddle_y_p2;
  logic          o_draw_ball, o_dir_x, o_dir_y, o_p1_score, o_p2_score;
  logic [CW-1:0] o_ball_x, o_ball_y;

  pong_ball_engine #(
    .C_GAME_WIDTH(W), .C_GAME_HEIGHT(H), .C_COORD_W(CW), .C_BALL_SPEED(SPD),
    .C_CNT_W(32), .C_PADDLE_HEIGHT(PH), .C_P1_COL(P1), .C_P2_COL(P2), .C_SERVE_TICKS(ST)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_game_active(i_game_active),
    .i_col_count_div(i_col_count_div), .i_row_count_div(i_row_count_div),
    .i_paddle_y_p1(i_paddle_y_p1), .i_paddle_y_p2(i_paddle_y_p2),
    .o_draw_ball(o_draw_ball), .o_ball_x(o_ball_x), .o_ball_y(o_ball_y),
    .o_dir_x(o_dir_x), .o_dir_y(o_dir_y), .o_p1_score(o_p1_score), .o_p2_score(o_p2_score)
  );

  always #20 i_clk = ~i_clk;

  int passed = 0, total = 0, fails = 0;

  // Game model: phase 0 idle, 1 run, 2 miss, 3 serve.
  int m_ph, m_x, m_y, m_dx, m_dy, m_cnt, m_srv, m_draw;
  int n_p1_seen = 0, n_p2_seen = 0, n_bounce = 0, n_corner = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_x = W / 2; m_y = H / 2; m_dx = 1; m_dy = 1; m_cnt = 0; m_srv = 0;
  endtask

  task automatic model_tick(output bit t);
    t = (m_cnt == SPD - 1);
    m_cnt = t ? 0 : m_cnt + 1;
  endtask

  // One clock of the game, using the inputs present at the edge.
  task automatic model_step();
    bit t, yb, xb;
    int nx, ny, p1, p2;
    p1 = int'(i_paddle_y_p1);
    p2 = int'(i_paddle_y_p2);
    m_draw = (int'(i_col_count_div) == m_x && int'(i_row_count_div) == m_y) ? 1 : 0;
    if (!i_game_active) begin
      model_reset();
      return;
    end
    case (m_ph)
      0: begin m_ph = 1; m_cnt = 0; end
      1: begin
        model_tick(t);
        if (t) begin
          yb = 0; xb = 0;
          if (m_dy == 1 && m_y == H - 1) begin m_dy = 0; ny = m_y - 1; yb = 1; end
          else if (m_dy == 0 && m_y == 0) begin m_dy = 1; ny = 1; yb = 1; end
          else ny = (m_dy == 1) ? m_y + 1 : m_y - 1;
          if (m_dx == 1 && m_x == P2 - 1 && m_y >= p2 && m_y <= p2 + PH - 1) begin
            m_dx = 0; nx = m_x - 1; xb = 1;
          end else if (m_dx == 0 && m_x == P1 + 1 && m_y >= p1 && m_y <= p1 + PH - 1) begin
            m_dx = 1; nx = m_x + 1; xb = 1;
          end else nx = (m_dx == 1) ? m_x + 1 : m_x - 1;
          if (xb) n_bounce++;
          if (xb && yb) n_corner++;
          m_x = nx; m_y = ny;
          if (nx == P2 || nx == P1) m_ph = 2;
        end
      end
      2: begin m_x = W / 2; m_y = H / 2; m_srv = 0; m_ph = 3; end
      default: begin
        model_tick(t);
        if (t) begin
          m_srv++;
          if (m_srv == ST) begin m_ph = 1; m_dx = 1 - m_dx; m_srv = 0; end
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("ball_x", o_ball_x, m_x);
    chk("ball_y", o_ball_y, m_y);
    chk("dir_x", o_dir_x, m_dx);
    chk("dir_y", o_dir_y, m_dy);
    chk("draw", o_draw_ball, m_draw);
    chk("p1_score", o_p1_score, (m_ph == 2 && m_x == P2 && i_game_active) ? 1 : 0);
    chk("p2_score", o_p2_score, (m_ph == 2 && m_x == P1 && i_game_active) ? 1 : 0);
    if (o_p1_score === 1'b1) n_p1_seen++;
    if (o_p2_score === 1'b1) n_p2_seen++;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    check_all();
  endtask

  function automatic logic [CW-1:0] near_pad(input int y);
    int v;
    v = y - int'($urandom_range(0, PH - 1));
    if (v < 0) v = 0;
    return CW'(v);
  endfunction

  initial begin
    int  drop_cnt = 0;
    bit  did_miss_drop = 0, did_async = 0;
    i_rst = 1'b1; i_game_active = 1'b0;
    i_col_count_div = '0; i_row_count_div = '0;
    i_paddle_y_p1 = '0; i_paddle_y_p2 = '0;
    model_reset(); m_draw = 0;
    #25;
    chk("rst_x", o_ball_x, 20);
    chk("rst_y", o_ball_y, 15);
    chk("rst_dx", o_dir_x, 1);
    chk("rst_dy", o_dir_y, 1);
    chk("rst_draw", o_draw_ball, 0);
    chk("rst_p1", o_p1_score, 0);
    chk("rst_p2", o_p2_score, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Draw scan while idle: centre cell hits one cycle later, transposed cell does not.
    i_col_count_div = 6'd20; i_row_count_div = 6'd15;
    cycle();
    chk("draw_centre", o_draw_ball, 1);
    i_col_count_div = 6'd15; i_row_count_div = 6'd20;
    cycle();
    chk("draw_transposed", o_draw_ball, 0);

    for (int c = 0; c < 8000; c++) begin
      if (drop_cnt > 0) begin
        i_game_active = 1'b0;
        drop_cnt--;
      end else if ($urandom_range(0, 999) == 0) begin
        i_game_active = 1'b0;
        drop_cnt = int'($urandom_range(0, 2));
      end else i_game_active = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        i_col_count_div = CW'(m_x); i_row_count_div = CW'(m_y);
      end else begin
        i_col_count_div = CW'($urandom_range(0, W - 1));
        i_row_count_div = CW'($urandom_range(0, H - 1));
      end
      i_paddle_y_p1 = ($urandom_range(0, 2) != 0) ? near_pad(m_y) : CW'($urandom_range(0, 63));
      i_paddle_y_p2 = ($urandom_range(0, 2) != 0) ? near_pad(m_y) : CW'($urandom_range(0, 63));
      cycle();

      // Drop the game during a miss: pulse must vanish and the next edge recentres.
      if (m_ph == 2 && !did_miss_drop && (n_p1_seen + n_p2_seen) >= 2) begin
        did_miss_drop = 1;
        i_game_active = 1'b0;
        drop_cnt = 1;
        #1;
        chk("miss_drop_p1", o_p1_score, 0);
        chk("miss_drop_p2", o_p2_score, 0);
      end

      // Asynchronous reset between edges during play.
      if (!did_async && c > 4000 && m_ph == 1) begin
        did_async = 1;
        #7 i_rst = 1'b1;
        #1;
        chk("arst_x", o_ball_x, 20);
        chk("arst_y", o_ball_y, 15);
        chk("arst_dx", o_dir_x, 1);
        chk("arst_dy", o_dir_y, 1);
        chk("arst_draw", o_draw_ball, 0);
        model_reset(); m_draw = 0;
        @(negedge i_clk);
        i_rst = 1'b0;
        check_all();
      end
    end

    chk("saw_p1_score", (n_p1_seen > 0) ? 1 : 0, 1);
    chk("saw_p2_score", (n_p2_seen > 0) ? 1 : 0, 1);
    chk("did_miss_drop", did_miss_drop, 1);
    chk("did_async_rst", did_async, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Parametrised next-generation ball controller for the VGA pong game.
- Moves the ball on a board-unit grid and bounces it off the top and bottom walls and both paddles.
- Detects misses, emits per-player score pulses and re-serves the ball after a hold-off.
- Sits between the paddle controllers and the pixel mux; consumes the divided VGA column/row counts and drives the ball draw enable.

Parameters:
- C_GAME_WIDTH, 40, board width in game units.
- C_GAME_HEIGHT, 30, board height in game units.
- C_COORD_W, 6, width of all game-unit coordinates; must hold max(C_GAME_WIDTH, C_GAME_HEIGHT)-1.
- C_BALL_SPEED, 1250000, clocks per ball step (50 ms at 25 MHz); must be >=2.
- C_CNT_W, 32, tick counter width.
- C_PADDLE_HEIGHT, 6, paddle length in game units.
- C_P1_COL, 0, P1 paddle column (left).
- C_P2_COL, 39, P2 paddle column (right); must equal C_GAME_WIDTH-1.
- C_SERVE_TICKS, 20, ball steps held at centre after a miss.

Ports:
- i_clk  in  1  25 MHz pixel clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_game_active  in  1  game running; low forces IDLE.
- i_col_count_div  in  C_COORD_W  current pixel column in game units.
- i_row_count_div  in  C_COORD_W  current pixel row in game units.
- i_paddle_y_p1  in  C_COORD_W  top row of the P1 paddle.
- i_paddle_y_p2  in  C_COORD_W  top row of the P2 paddle.
- o_draw_ball  out  1  ball occupies the current pixel cell.
- o_ball_x  out  C_COORD_W  ball column.
- o_ball_y  out  C_COORD_W  ball row.
- o_dir_x  out  1  1 = moving right.
- o_dir_y  out  1  1 = moving down.
- o_p1_score  out  1  one-cycle pulse when P1 scores.
- o_p2_score  out  1  one-cycle pulse when P2 scores.

Behaviour:
- Reset values:
  - o_ball_x = C_GAME_WIDTH/2, o_ball_y = C_GAME_HEIGHT/2.
  - o_dir_x = 1, o_dir_y = 1.
  - o_draw_ball, o_p1_score and o_p2_score = 0.
  - Tick counter = 0, serve counter = 0, state = IDLE.
- Tick:
  - Counter runs 0..C_BALL_SPEED-1 only in RUN and SERVE.
  - tick = 1 for one cycle when the counter equals C_BALL_SPEED-1; the counter then wraps to 0.
  - Counter is cleared when entering IDLE.
- States:
  - IDLE: ball held at centre. Go to RUN on the first cycle i_game_active = 1.
  - RUN: on a tick, update X and Y independently and simultaneously (corner = both axes reflect on the same tick).
  - MISS: lasts exactly one cycle. Recentre the ball, assert the scorer's pulse, clear the serve counter, go to SERVE.
  - SERVE: ball held at centre; count ticks. After C_SERVE_TICKS ticks go to RUN with o_dir_x pointing toward the player who scored. o_dir_y is unchanged.
  - i_game_active = 0 in any state: next state is IDLE with the reset position, reset directions and counters. Score pulses are suppressed.
- Y axis, on a tick in RUN:
  - o_dir_y = 1 and y = C_GAME_HEIGHT-1: set o_dir_y = 0 and y = y-1.
  - o_dir_y = 0 and y = 0: set o_dir_y = 1 and y = y+1.
  - Otherwise step y by ±1 in the current direction.
- X axis, on a tick in RUN:
  - Moving right and x = C_P2_COL-1:
    - if ball y is in [i_paddle_y_p2, i_paddle_y_p2+C_PADDLE_HEIGHT-1], set o_dir_x = 0 and x = x-1 (bounce);
    - else x = x+1.
  - Moving left and x = C_P1_COL+1: mirror image using i_paddle_y_p1.
  - x reaching C_P2_COL: P1 scores, go to MISS.
  - x reaching C_P1_COL: P2 scores, go to MISS.
  - Paddle hit test uses the pre-update y and the paddle inputs sampled on the tick cycle.
- Paddle-range arithmetic is done at C_COORD_W+1 bits so a paddle at the bottom does not wrap.
- Draw: registered, 1-cycle latency.
  - o_draw_ball = (i_col_count_div == o_ball_x) && (i_row_count_div == o_ball_y).
  - Active in all states.

Optional Feature:
- Macro PONG_BALL_SPEEDUP_EN.
- When defined:
  - Parameters C_SPEEDUP_STEP (default 62500) and C_BALL_SPEED_MIN (default 312500) are added.
  - Each paddle bounce reduces the active tick period by C_SPEEDUP_STEP, saturating at C_BALL_SPEED_MIN.
  - Period returns to C_BALL_SPEED on MISS or IDLE.
- When undefined: period fixed at C_BALL_SPEED and no extra logic is present.

Decomposition:
- pong_pkg holds:
  - the state enum {IDLE, RUN, MISS, SERVE};
  - direction constants DIR_RIGHT/DIR_DOWN = 1;
  - default board dimensions and the default speed.
- One sub-module, pong_tick_gen: programmable-period counter with clear and enable, producing the tick pulse. The period is an input, so the speed-up needs no change inside it.

Test Plan (sim with C_BALL_SPEED=4, C_SERVE_TICKS=2):
- i_rst pulsed mid-RUN, asynchronously between clock edges -> outputs return to x=20, y=15, dir 1/1, state IDLE immediately.
- Active, ball at (37,10) moving right, i_paddle_y_p2=8 -> reaches x=38, next tick x=37, o_dir_x=0, no score pulse.
- Same but i_paddle_y_p2=20 -> x=39, o_p1_score high for exactly 1 cycle, then ball at (20,15), and after 2 ticks moving left.
- Ball at (10,29) moving down-right -> next tick (11,28), o_dir_y=0.
- i_game_active dropped on the MISS cycle -> no score pulse, IDLE, centred.
- Scan i_col_count_div=20, i_row_count_div=15 after reset -> o_draw_ball=1 one cycle later; col=15, row=20 -> 0.
